// File: rtl/oled_spi_tx.sv
// SPI Mode 3 write-only transmitter for the Pmod OLEDrgb (SSD1331) serial pins.
// Define OLED_SPI_BURST_EN to let a new byte chain onto the current CS frame from HOLD.
module oled_spi_tx #(
  parameter int CLK_DIV = 8,
  parameter int CS_HOLD = 8,
  parameter int CS_GAP  = 8
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic       tx_valid_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_dc_i,
  output logic       tx_ready_o,
  output logic       busy_o,
  output logic       spi_sck_o,
  output logic       spi_cs_o,
  output logic       spi_mosi_o,
  output logic       spi_dc_o
);

  localparam int MAX_HD  = (CLK_DIV > CS_HOLD) ? CLK_DIV : CS_HOLD;
  localparam int MAX_ALL = (MAX_HD > CS_GAP) ? MAX_HD : CS_GAP;
  localparam int CNT_W   = $clog2(MAX_ALL + 1);

  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(CS_HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(CS_GAP - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] halfCnt_q;
  logic [2:0]       bitCnt_q;
  logic [7:0]       shift_q;
  logic             txReady_q;
  logic             busy_q;
  logic             sck_q;
  logic             cs_q;
  logic             mosi_q;
  logic             dc_q;

  logic take;
  logic cntDone;

  // txReady_q is only ever high in states that may accept a byte, so a
  // transfer is simply valid && ready regardless of the current state.
  assign take    = tx_valid_i && txReady_q;
  assign cntDone = (halfCnt_q == '0);

  always_ff @(posedge sclk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      halfCnt_q <= '0;
      bitCnt_q  <= '0;
      shift_q   <= '0;
      txReady_q <= 1'b0;
      busy_q    <= 1'b0;
      sck_q     <= 1'b1;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
      dc_q      <= 1'b0;
    end else if (take) begin
      state_q   <= SETUP;
      halfCnt_q <= DIV_LOAD;
      bitCnt_q  <= 3'd7;
      shift_q   <= tx_data_i;
      dc_q      <= tx_dc_i;
      mosi_q    <= tx_data_i[7];
      cs_q      <= 1'b0;
      sck_q     <= 1'b1;
      txReady_q <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          txReady_q <= 1'b1;
          busy_q    <= 1'b0;
        end
        SETUP: begin
          if (cntDone) begin
            state_q   <= SHIFT;
            sck_q     <= 1'b0;
            halfCnt_q <= DIV_LOAD;
          end else begin
            halfCnt_q <= halfCnt_q - CNT_ONE;
          end
        end
        // sck_q doubles as the phase flag: low phase ends with a rising
        // edge, high phase ends with the next bit on a falling edge.
        SHIFT: begin
          if (!cntDone) begin
            halfCnt_q <= halfCnt_q - CNT_ONE;
          end else if (!sck_q) begin
            sck_q     <= 1'b1;
            halfCnt_q <= DIV_LOAD;
          end else if (bitCnt_q == 3'd0) begin
            state_q   <= HOLD;
            halfCnt_q <= HOLD_LOAD;
`ifdef OLED_SPI_BURST_EN
            txReady_q <= 1'b1;
`else
            txReady_q <= 1'b0;
`endif
          end else begin
            bitCnt_q  <= bitCnt_q - 3'd1;
            sck_q     <= 1'b0;
            mosi_q    <= shift_q[bitCnt_q - 3'd1];
            halfCnt_q <= DIV_LOAD;
          end
        end
        HOLD: begin
          if (cntDone) begin
            state_q   <= GAP;
            cs_q      <= 1'b1;
            txReady_q <= 1'b0;
            halfCnt_q <= GAP_LOAD;
          end else begin
            halfCnt_q <= halfCnt_q - CNT_ONE;
          end
        end
        GAP: begin
          if (cntDone) begin
            state_q   <= IDLE;
            txReady_q <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            halfCnt_q <= halfCnt_q - CNT_ONE;
          end
        end
        default: begin
          state_q   <= IDLE;
          txReady_q <= 1'b0;
          busy_q    <= 1'b0;
          sck_q     <= 1'b1;
          cs_q      <= 1'b1;
        end
      endcase
    end
  end

  assign tx_ready_o = txReady_q;
  assign busy_o     = busy_q;
  assign spi_sck_o  = sck_q;
  assign spi_cs_o   = cs_q;
  assign spi_mosi_o = mosi_q;
  assign spi_dc_o   = dc_q;

endmodule
